// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg
//   Shared definitions for the sequential restoring divider: FSM state
//   encodings, default operand width and the iteration-counter width.
package seq_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam int DIV_WIDTH = 32;

    // The counter must be able to hold WIDTH itself, hence the extra bit.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/seq_divider_cla_sub.sv
// cla_sub
//   N-bit carry-lookahead subtractor: D = X + ~Y + 1.
//   Carries come from a parallel-prefix (Kogge-Stone) generate/propagate
//   tree. The carry-in of 1 is folded into the bit-0 generate term.
// Ports
//   X, Y      in   N  minuend / subtrahend
//   D         out  N  difference
//   NOBORROW  out  1  carry-out; 1 when X >= Y (unsigned)
module cla_sub
    import seq_divider_pkg::*;
#(
    parameter int N = DIV_WIDTH + 1
) (
    input  logic [N-1:0] X,
    input  logic [N-1:0] Y,
    output logic [N-1:0] D,
    output logic         NOBORROW
);

    logic [N-1:0] p;
    logic [N-1:0] g;
    logic [N-1:0] gg;
    logic [N-1:0] pp;
    logic [N-1:0] gg_n;
    logic [N-1:0] pp_n;
    logic [N-1:0] carry;

    always_comb begin
        p     = X ^ ~Y;
        g     = X & ~Y;
        gg    = g;
        gg[0] = g[0] | p[0];
        pp    = p;
        gg_n  = gg;
        pp_n  = pp;
        // After the prefix tree, gg[i] is the carry out of bit i.
        for (int d = 1; d < N; d = d * 2) begin
            gg_n = gg;
            pp_n = pp;
            for (int i = d; i < N; i++) begin
                gg_n[i] = gg[i] | (pp[i] & gg[i-d]);
                pp_n[i] = pp[i] & pp[i-d];
            end
            gg = gg_n;
            pp = pp_n;
        end
        carry    = {gg[N-2:0], 1'b1};
        D        = p ^ carry;
        NOBORROW = gg[N-1];
    end

endmodule

// File: rtl/seq_divider.sv
// seq_divider
//   Sequential unsigned restoring divider, one quotient bit per clock.
//
//   state | meaning
//   IDLE  | waiting for START
//   RUN   | iterating, one quotient bit per cycle (BUSY=1)
//   FIN   | result presented, DONE=1 for this cycle, START accepted
//
// Ports
//   CLK, RST  in   1      clock (rising edge), synchronous active-high reset
//   START     in   1      request strobe, ignored while BUSY
//   A, B      in   WIDTH  dividend, divisor (sampled on accepted START)
//   BUSY      out  1      division in progress
//   DONE      out  1      one-cycle pulse, Q/R/DIVZ valid from this cycle
//   Q, R      out  WIDTH  quotient, remainder (held until next result)
//   DIVZ      out  1      divisor was zero
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             DIVZ
);

    localparam int            CW        = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] qreg_q, qreg_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             divz_q, divz_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             no_borrow;
    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] qreg_next;
    logic             unused_rem_msb;

    // The partial remainder stays below the divisor, so its top bit is
    // always zero between iterations; only the low WIDTH bits feed the shift.
    assign unused_rem_msb = rem_q[WIDTH];

    assign shifted = {rem_q[WIDTH-1:0], qreg_q[WIDTH-1]};

    cla_sub #(.N(WIDTH + 1)) u_sub (
        .X        (shifted),
        .Y        ({1'b0, div_q}),
        .D        (trial),
        .NOBORROW (no_borrow)
    );

    always_comb begin
        rem_next  = no_borrow ? trial : shifted;
        qreg_next = {qreg_q[WIDTH-2:0], no_borrow};

        state_d = state_q;
        cnt_d   = cnt_q;
        qreg_d  = qreg_q;
        div_d   = div_q;
        rem_d   = rem_q;
        q_d     = q_q;
        r_d     = r_q;
        divz_d  = divz_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            RUN: begin
                qreg_d = qreg_next;
                rem_d  = rem_next;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    state_d = FIN;
                    done_d  = 1'b1;
                    q_d     = qreg_next;
                    r_d     = rem_next[WIDTH-1:0];
                    divz_d  = 1'b0;
                end else begin
                    busy_d  = 1'b1;
                end
            end
            default: begin
                // IDLE and FIN both accept a new request.
                state_d = IDLE;
                if (START) begin
                    if (B == '0) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                        q_d     = '1;
                        r_d     = A;
                        divz_d  = 1'b1;
                    end else begin
                        state_d = RUN;
                        busy_d  = 1'b1;
                        qreg_d  = A;
                        div_d   = B;
                        rem_d   = '0;
                        cnt_d   = '0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            qreg_q  <= '0;
            div_q   <= '0;
            rem_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            divz_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            qreg_q  <= qreg_d;
            div_q   <= div_d;
            rem_q   <= rem_d;
            q_q     <= q_d;
            r_q     <= r_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            divz_q  <= divz_d;
        end
    end

    assign BUSY = busy_q;
    assign DONE = done_q;
    assign Q    = q_q;
    assign R    = r_q;
    assign DIVZ = divz_q;

endmodule
